// File: rtl/mbus_lc_reg_responder_if.sv
// LC-side MBus handshake bundle shared by the register responder and its bus-side peer.
// master = bus/isolation side, slave = layer-controller responder.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface mbus_lc_reg_responder_if;
  logic [`ADDR_WIDTH-1:0] RX_ADDR;
  logic [`DATA_WIDTH-1:0] RX_DATA;
  logic                   RX_REQ;
  logic                   RX_ACK;
  logic                   RX_BROADCAST;
  logic                   RX_FAIL;
  logic                   RX_PEND;
  logic [`ADDR_WIDTH-1:0] TX_ADDR;
  logic [`DATA_WIDTH-1:0] TX_DATA;
  logic                   TX_REQ;
  logic                   TX_PEND;
  logic                   TX_PRIORITY;
  logic                   TX_ACK;
  logic                   TX_SUCC;
  logic                   TX_FAIL;
  logic                   TX_RESP_ACK;

  modport master (
    output RX_ADDR, RX_DATA, RX_REQ, RX_BROADCAST, RX_FAIL, RX_PEND,
           TX_ACK, TX_SUCC, TX_FAIL,
    input  RX_ACK, TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK
  );

  modport slave (
    input  RX_ADDR, RX_DATA, RX_REQ, RX_BROADCAST, RX_FAIL, RX_PEND,
           TX_ACK, TX_SUCC, TX_FAIL,
    output RX_ACK, TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK
  );
endinterface

// File: rtl/mbus_lc_reg_responder.sv
// MBus LC register responder: RX writes update a 24-bit register file, RX reads send one reply word.
// Define MBUS_LC_TX_RETRY_EN to re-send a failed reply up to two more times.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mbus_lc_reg_responder #(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [3:0]  FUNC_WR  = 4'h2,
  parameter logic [3:0]  FUNC_RD  = 4'h3
) (
  input  logic                      CLK,
  input  logic                      RESET,
  mbus_lc_reg_responder_if.slave    bus,
  output logic [NUM_REGS*24-1:0]    REG_FILE
);
  localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_RX_HOLD, S_TX_REQ, S_TX_DROP, S_TX_WAIT, S_TX_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            rx_ack_q, rx_ack_d;
  logic            tx_req_q, tx_req_d;
  logic            tx_resp_ack_q, tx_resp_ack_d;
  logic            burst_q, burst_d;
  logic            rd_pend_q, rd_pend_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [AW-1:0]   tx_addr_q, tx_addr_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic [23:0]     regs_q [NUM_REGS];
  logic [23:0]     regs_d [NUM_REGS];
`ifdef MBUS_LC_TX_RETRY_EN
  logic [1:0]      retry_cnt_q, retry_cnt_d;
  logic            tx_fail_q, tx_fail_d;
`endif

  logic [7:0]      rx_idx;
  logic [3:0]      func;
  logic            rx_in_range;
  logic [IW-1:0]   wr_tgt;
  logic            wr_ok;
  logic [23:0]     rd_word;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^bus.RX_ADDR[AW-1:4];

  always_comb begin
    rx_idx      = bus.RX_DATA[31:24];
    func        = bus.RX_ADDR[3:0];
    rx_in_range = 32'(rx_idx) < NUM_REGS;
    // Inside a burst the target follows the previous write and wraps, ignoring RX_DATA[31:24].
    wr_tgt      = burst_q ? wr_idx_q + 1'b1 : rx_idx[IW-1:0];
    wr_ok       = burst_q || rx_in_range;
    rd_word     = rx_in_range ? regs_q[rx_idx[IW-1:0]] : '0;
  end

  always_comb begin
    state_d       = state_q;
    rx_ack_d      = rx_ack_q;
    tx_req_d      = tx_req_q;
    tx_resp_ack_d = tx_resp_ack_q;
    burst_d       = burst_q;
    rd_pend_d     = rd_pend_q;
    wr_idx_d      = wr_idx_q;
    tx_addr_d     = tx_addr_q;
    tx_data_d     = tx_data_q;
    regs_d        = regs_q;
`ifdef MBUS_LC_TX_RETRY_EN
    retry_cnt_d   = retry_cnt_q;
    tx_fail_d     = tx_fail_q;
`endif

    if (bus.RX_FAIL) burst_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.RX_REQ) begin
          rx_ack_d  = 1'b1;
          state_d   = S_RX_HOLD;
          burst_d   = bus.RX_PEND && !bus.RX_FAIL;
          rd_pend_d = 1'b0;
          if (!bus.RX_BROADCAST) begin
            if (func == FUNC_WR) begin
              if (wr_ok) begin
                regs_d[wr_tgt] = bus.RX_DATA[23:0];
                wr_idx_d       = wr_tgt;
              end
            end else if (func == FUNC_RD && !bus.RX_FAIL) begin
              rd_pend_d = 1'b1;
              tx_addr_d = AW'(bus.RX_DATA[15:8]);
              tx_data_d = DW'({rx_idx, rd_word});
`ifdef MBUS_LC_TX_RETRY_EN
              retry_cnt_d = '0;
`endif
            end
          end
        end
      end
      S_RX_HOLD: begin
        if (bus.RX_FAIL) rd_pend_d = 1'b0;
        if (!bus.RX_REQ) begin
          rx_ack_d  = 1'b0;
          rd_pend_d = 1'b0;
          if (rd_pend_q && !bus.RX_FAIL) begin
            tx_req_d = 1'b1;
            state_d  = S_TX_REQ;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      S_TX_REQ: begin
        if (bus.TX_ACK) begin
          tx_req_d = 1'b0;
          state_d  = S_TX_DROP;
        end
      end
      S_TX_DROP: begin
        if (!bus.TX_ACK) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (bus.TX_SUCC || bus.TX_FAIL) begin
          tx_resp_ack_d = 1'b1;
          state_d       = S_TX_RESP;
`ifdef MBUS_LC_TX_RETRY_EN
          tx_fail_d     = bus.TX_FAIL;
`endif
        end
      end
      S_TX_RESP: begin
        if (!bus.TX_SUCC && !bus.TX_FAIL) begin
          tx_resp_ack_d = 1'b0;
          state_d       = S_IDLE;
`ifdef MBUS_LC_TX_RETRY_EN
          if (tx_fail_q && retry_cnt_q != 2'd2) begin
            retry_cnt_d = retry_cnt_q + 2'd1;
            tx_req_d    = 1'b1;
            state_d     = S_TX_REQ;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      rx_ack_q      <= 1'b0;
      tx_req_q      <= 1'b0;
      tx_resp_ack_q <= 1'b0;
      burst_q       <= 1'b0;
      rd_pend_q     <= 1'b0;
      wr_idx_q      <= '0;
      tx_addr_q     <= '0;
      tx_data_q     <= '0;
      regs_q        <= '{default: '0};
`ifdef MBUS_LC_TX_RETRY_EN
      retry_cnt_q   <= '0;
      tx_fail_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rx_ack_q      <= rx_ack_d;
      tx_req_q      <= tx_req_d;
      tx_resp_ack_q <= tx_resp_ack_d;
      burst_q       <= burst_d;
      rd_pend_q     <= rd_pend_d;
      wr_idx_q      <= wr_idx_d;
      tx_addr_q     <= tx_addr_d;
      tx_data_q     <= tx_data_d;
      regs_q        <= regs_d;
`ifdef MBUS_LC_TX_RETRY_EN
      retry_cnt_q   <= retry_cnt_d;
      tx_fail_q     <= tx_fail_d;
`endif
    end
  end

  always_comb begin
    REG_FILE = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) REG_FILE[i*24 +: 24] = regs_q[i];
  end

  assign bus.RX_ACK      = rx_ack_q;
  assign bus.TX_REQ      = tx_req_q;
  assign bus.TX_RESP_ACK = tx_resp_ack_q;
  assign bus.TX_ADDR     = tx_addr_q;
  assign bus.TX_DATA     = tx_data_q;
  assign bus.TX_PEND     = 1'b0;
  assign bus.TX_PRIORITY = 1'b0;
endmodule

// File: tb/tb_mbus_lc_reg_responder.sv
// Directed bench for mbus_lc_reg_responder with a register-file/reply model checked every cycle.
module tb_mbus_lc_reg_responder;
  localparam int NREG = 8;

  logic                 CLK;
  logic                 RESET;
  logic [NREG*24-1:0]   REG_FILE;
  mbus_lc_reg_responder_if bus();

  mbus_lc_reg_responder #(.NUM_REGS(NREG), .FUNC_WR(4'h2), .FUNC_RD(4'h3)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .REG_FILE(REG_FILE)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic [23:0] m_regs [NREG];
  bit          m_burst;
  int          m_last;
  logic [31:0] exp_tx_addr;
  logic [31:0] exp_tx_data;
  bit          mon_en;
  int          tx_rises;
  logic [31:0] bp_addr, bp_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] dut_reg(input int i);
    return REG_FILE[i*24 +: 24];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = 24'h0;
    m_burst = 0;
    m_last  = 0;
  endfunction

  function automatic void model_rx(input logic [31:0] addr, input logic [31:0] data,
                                   input bit pend, input bit bcast);
    int idx;
    int rd;
    idx = m_burst ? (m_last + 1) % NREG : int'(data[31:24]);
    if (!bcast && addr[3:0] == 4'h2 && idx < NREG) begin
      m_regs[idx] = data[23:0];
      m_last      = idx;
    end
    if (!bcast && addr[3:0] == 4'h3) begin
      rd          = int'(data[31:24]);
      exp_tx_addr = {24'h0, data[15:8]};
      exp_tx_data = {data[31:24], (rd < NREG) ? m_regs[rd] : 24'h0};
    end
    m_burst = pend;
  endfunction

  // One RX word through the four-phase handshake; model updates on the cycle RX_ACK rises.
  task automatic rx_word(input logic [31:0] addr, input logic [31:0] data,
                         input bit pend, input bit bcast, input bit fail_in_hold);
    int n;
    bus.RX_ADDR = addr; bus.RX_DATA = data; bus.RX_PEND = pend;
    bus.RX_BROADCAST = bcast; bus.RX_REQ = 1'b1;
    n = 0;
    while (!bus.RX_ACK && n < 20) begin tick(); n++; end
    chk("rx_ack_rise", 64'(bus.RX_ACK), 64'd1);
    model_rx(addr, data, pend, bcast);
    if (fail_in_hold) begin
      bus.RX_FAIL = 1'b1;
      m_burst = 0;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rx_ack_hold", 64'(bus.RX_ACK), 64'd1);
    end
    bus.RX_REQ = 1'b0;
    tick();
    chk("rx_ack_drop", 64'(bus.RX_ACK), 64'd0);
    bus.RX_FAIL = 1'b0; bus.RX_PEND = 1'b0; bus.RX_BROADCAST = 1'b0;
  endtask

  task automatic rx_fail_pulse();
    bus.RX_FAIL = 1'b1;
    tick();
    bus.RX_FAIL = 1'b0;
    m_burst = 0;
  endtask

  // Bus-side TX peer. mode: 0 succ, 1 fail, 2 succ+fail together.
  task automatic serve_tx(input int mode, input int max_att, input bit bp, output int attempts);
    int n;
    attempts = 0;
    while (attempts < max_att) begin
      n = 0;
      while (!bus.TX_REQ && n < 20) begin tick(); n++; end
      if (!bus.TX_REQ) break;
      attempts++;
      tick();
      bus.TX_ACK = 1'b1;
      n = 0;
      while (bus.TX_REQ && n < 20) begin tick(); n++; end
      chk("tx_req_drop", 64'(bus.TX_REQ), 64'd0);
      bus.TX_ACK = 1'b0;
      tick(); tick();
      if (bp) begin
        bus.RX_ADDR = bp_addr; bus.RX_DATA = bp_data; bus.RX_PEND = 1'b0; bus.RX_REQ = 1'b1;
        tick(); tick();
        chk("bp_no_ack_wait", 64'(bus.RX_ACK), 64'd0);
      end
      bus.TX_SUCC = (mode != 1);
      bus.TX_FAIL = (mode != 0);
      n = 0;
      while (!bus.TX_RESP_ACK && n < 20) begin tick(); n++; end
      chk("resp_ack_rise", 64'(bus.TX_RESP_ACK), 64'd1);
      tick();
      chk("resp_ack_hold", 64'(bus.TX_RESP_ACK), 64'd1);
      if (bp) chk("bp_no_ack_resp", 64'(bus.RX_ACK), 64'd0);
      bus.TX_SUCC = 1'b0; bus.TX_FAIL = 1'b0;
      tick();
      chk("resp_ack_drop", 64'(bus.TX_RESP_ACK), 64'd0);
      if (bp) chk("bp_no_ack_drop", 64'(bus.RX_ACK), 64'd0);
    end
  endtask

  // Per-cycle comparison against the model
  logic tx_req_prev = 1'b0;
  initial begin
    logic [NREG*24-1:0] exp_flat;
    forever begin
      @(negedge CLK);
      if (!RESET && mon_en) begin
        for (int i = 0; i < NREG; i++) exp_flat[i*24 +: 24] = m_regs[i];
        checks++;
        if (REG_FILE !== exp_flat) begin
          errors++;
          $display("FAIL regfile: got %h expected %h", REG_FILE, exp_flat);
        end
        chk("tx_pend", 64'(bus.TX_PEND), 64'd0);
        chk("tx_prio", 64'(bus.TX_PRIORITY), 64'd0);
        if (bus.TX_REQ) begin
          chk("tx_addr", 64'(bus.TX_ADDR), 64'(exp_tx_addr));
          chk("tx_data", 64'(bus.TX_DATA), 64'(exp_tx_data));
        end
        if (bus.TX_REQ && !tx_req_prev) tx_rises++;
        tx_req_prev = bus.TX_REQ;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int att;
    int base;
    int exp_fail_att;
    mon_en = 0; tx_rises = 0;
    bp_addr = 32'h0; bp_data = 32'h0;
    exp_tx_addr = 32'h0; exp_tx_data = 32'h0;
    model_reset();
    bus.RX_ADDR = '0; bus.RX_DATA = '0; bus.RX_REQ = 0; bus.RX_BROADCAST = 0;
    bus.RX_FAIL = 0; bus.RX_PEND = 0; bus.TX_ACK = 0; bus.TX_SUCC = 0; bus.TX_FAIL = 0;
    RESET = 1'b1;
    repeat (3) tick();
    chk("rst_rx_ack", 64'(bus.RX_ACK), 64'd0);
    chk("rst_tx_req", 64'(bus.TX_REQ), 64'd0);
    chk("rst_resp_ack", 64'(bus.TX_RESP_ACK), 64'd0);
    chk("rst_tx_addr", 64'(bus.TX_ADDR), 64'd0);
    chk("rst_tx_data", 64'(bus.TX_DATA), 64'd0);
    chk("rst_regfile_or", 64'(|REG_FILE), 64'd0);
    RESET = 1'b0;
    mon_en = 1;
    tick();

    // Single write
    rx_word(32'h02, 32'h05ABCDEF, 0, 0, 0);
    repeat (3) tick();
    chk("wr_reg5", 64'(dut_reg(5)), 64'h00ABCDEF);
    chk("wr_no_tx", 64'(tx_rises), 64'd0);

    // Burst with wrap
    rx_word(32'h02, 32'h07000001, 1, 0, 0);
    rx_word(32'h02, 32'h00000002, 1, 0, 0);
    rx_word(32'h02, 32'h00000003, 0, 0, 0);
    tick();
    chk("burst_reg7", 64'(dut_reg(7)), 64'h1);
    chk("burst_reg0", 64'(dut_reg(0)), 64'h2);
    chk("burst_reg1", 64'(dut_reg(1)), 64'h3);

    // Read reg5 -> reply to 0x41
    rx_word(32'h03, 32'h05004100, 0, 0, 0);
    chk("rd_tx_req", 64'(bus.TX_REQ), 64'd1);
    chk("rd_tx_addr_lit", 64'(bus.TX_ADDR), 64'h41);
    chk("rd_tx_data_lit", 64'(bus.TX_DATA), 64'h05ABCDEF);
    serve_tx(0, 2, 0, att);
    chk("rd_attempts", 64'(att), 64'd1);

    // Out-of-range write / read, broadcast write
    rx_word(32'h02, 32'h09111111, 0, 0, 0);
    tick();
    chk("oor_wr_reg1", 64'(dut_reg(1)), 64'h3);
    rx_word(32'h03, 32'h09004200, 0, 0, 0);
    chk("oor_rd_data_lit", 64'(bus.TX_DATA), 64'h09000000);
    serve_tx(0, 1, 0, att);
    rx_word(32'h02, 32'h05123456, 0, 1, 0);
    tick();
    chk("bcast_reg5", 64'(dut_reg(5)), 64'h00ABCDEF);

    // Back-pressure: write arrives during TX_WAIT, acked only after TX_RESP
    bp_addr = 32'h02; bp_data = 32'h02000055;
    rx_word(32'h03, 32'h07004400, 0, 0, 0);
    serve_tx(0, 1, 1, att);
    chk("bp_attempts", 64'(att), 64'd1);
    rx_word(bp_addr, bp_data, 0, 0, 0);
    tick();
    chk("bp_reg2", 64'(dut_reg(2)), 64'h55);

    // RX_FAIL mid-burst: next write uses its own index
    rx_word(32'h02, 32'h04000010, 1, 0, 0);
    rx_fail_pulse();
    rx_word(32'h02, 32'h06000020, 0, 0, 0);
    tick();
    chk("fail_reg6", 64'(dut_reg(6)), 64'h20);
    chk("fail_reg5", 64'(dut_reg(5)), 64'h00ABCDEF);

    // Read cancelled by RX_FAIL during RX_HOLD
    base = tx_rises;
    rx_word(32'h03, 32'h01004300, 0, 0, 1);
    repeat (10) tick();
    chk("cancel_no_tx", 64'(tx_rises - base), 64'd0);

`ifdef MBUS_LC_TX_RETRY_EN
    exp_fail_att = 3;
`else
    exp_fail_att = 1;
`endif
    // TX_FAIL and SUCC+FAIL both count as failure
    rx_word(32'h03, 32'h01004500, 0, 0, 0);
    serve_tx(1, 4, 0, att);
    chk("txfail_attempts", 64'(att), 64'(exp_fail_att));
    rx_word(32'h03, 32'h07004600, 0, 0, 0);
    serve_tx(2, 4, 0, att);
    chk("both_attempts", 64'(att), 64'(exp_fail_att));

    // Async reset while TX_REQ is high
    rx_word(32'h03, 32'h05004700, 0, 0, 0);
    chk("pre_rst_tx_req", 64'(bus.TX_REQ), 64'd1);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    chk("async_tx_req", 64'(bus.TX_REQ), 64'd0);
    chk("async_rx_ack", 64'(bus.RX_ACK), 64'd0);
    chk("async_resp_ack", 64'(bus.TX_RESP_ACK), 64'd0);
    chk("async_regfile_or", 64'(|REG_FILE), 64'd0);
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    chk("post_rst_tx_req", 64'(bus.TX_REQ), 64'd0);
    chk("post_rst_reg5", 64'(dut_reg(5)), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
